// File: rtl/ap_pkg.sv
// Shared definitions for the match reader: FSM state encoding and the array
// access-mode codes understood by the CAM array.
package ap_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEL  = 3'd1,
        CAP  = 3'd2,
        EMIT = 3'd3,
        DONE = 3'd4
    } state_e;

    localparam logic [2:0] MODE_NONE    = 3'd0;
    localparam logic [2:0] MODE_ROWXROW = 3'd1;
    localparam logic [2:0] MODE_COLXCOL = 3'd2;
    localparam logic [2:0] MODE_COPY    = 3'd3;

endpackage

// File: rtl/match_reader_if.sv
// Result stream carrying one matched row (index + contents) per beat.
interface match_reader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    // A beat transfers on a rising clk edge where out_valid and out_ready are both 1.
    // Once out_valid rises, out_addr/out_data stay stable and out_valid stays high
    // until that transfer; out_ready may toggle freely and never gates out_valid.
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (output out_valid, output out_addr, output out_data, input  out_ready);
    modport slave  (input  out_valid, input  out_addr, input  out_data, output out_ready);

endinterface

// File: rtl/lsb_prio_enc.sv
// Lowest-set-bit priority encoder: returns the index of the least significant
// set bit of req and whether any bit is set at all.
module lsb_prio_enc #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 8
) (
    input  logic [WIDTH-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) idx = IDX_W'(i);
        end
    end

    assign any = |req;

endmodule

// File: rtl/match_reader.sv
// Scans a latched tag vector and streams each matched array row, lowest index first.
// Optional macro MATCH_READER_COUNT_EN builds the match_count counter (tied to 0 otherwise).
module match_reader
    import ap_pkg::*;
#(
    parameter int         DATA_WIDTH     = 8,
    parameter int         DATA_DEPTH     = 16,
    parameter int         ADDR_WIDTH_CAM = 8,
    parameter logic [2:0] RowxRow        = MODE_ROWXROW
) (
    input  logic                      clk,
    input  logic                      rstIn,
    input  logic                      start,
    input  logic [DATA_DEPTH-1:0]     tag,
    input  logic [DATA_WIDTH-1:0]     Q_out_row,
    output logic [ADDR_WIDTH_CAM-1:0] addr_output_Row,
    output logic [2:0]                input_mode,
    output logic                      busy,
    output logic                      done,
    output logic [ADDR_WIDTH_CAM-1:0] match_count,
    output state_e                    state_dbg,
    match_reader_if.master            out_if
);

    state_e                    state_q, state_d;
    logic [DATA_DEPTH-1:0]     snap_q, snap_d;
    logic [ADDR_WIDTH_CAM-1:0] out_addr_q, out_addr_d;
    logic [DATA_WIDTH-1:0]     out_data_q, out_data_d;

    logic [ADDR_WIDTH_CAM-1:0] sel_idx;
    logic                      sel_any;
    logic [DATA_DEPTH-1:0]     snap_rest;
    logic                      hs;
    logic                      out_valid;

    lsb_prio_enc #(
        .WIDTH (DATA_DEPTH),
        .IDX_W (ADDR_WIDTH_CAM)
    ) u_enc (
        .req (snap_q),
        .idx (sel_idx),
        .any (sel_any)
    );

    // Snapshot with its lowest set bit removed: what remains after the current beat.
    assign snap_rest = snap_q & (snap_q - DATA_DEPTH'(1));
    assign hs        = (state_q == EMIT) && out_if.out_ready;

    always_ff @(posedge clk or negedge rstIn) begin
        if (!rstIn) begin
            state_q    <= IDLE;
            snap_q     <= '0;
            out_addr_q <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d  = tag;
                    state_d = (tag == '0) ? DONE : SEL;
                end
            end
            SEL:  state_d = sel_any ? CAP : DONE;
            CAP: begin
                out_addr_d = sel_idx;
                out_data_d = Q_out_row;
                state_d    = EMIT;
            end
            EMIT: begin
                if (hs) begin
                    snap_d  = snap_rest;
                    state_d = (snap_rest != '0) ? SEL : DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The row address is held through CAP so a registered array read lines up.
    always_comb begin
        busy            = 1'b0;
        done            = 1'b0;
        out_valid       = 1'b0;
        addr_output_Row = '0;
        input_mode      = MODE_NONE;
        case (state_q)
            SEL, CAP: begin
                busy            = 1'b1;
                addr_output_Row = sel_idx;
            end
            EMIT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
        if (busy) input_mode = RowxRow;
    end

    assign out_if.out_valid = out_valid;
    assign out_if.out_addr  = out_addr_q;
    assign out_if.out_data  = out_data_q;
    assign state_dbg        = state_q;

`ifdef MATCH_READER_COUNT_EN
    logic [ADDR_WIDTH_CAM-1:0] count_q, count_d;

    always_ff @(posedge clk or negedge rstIn) begin
        if (!rstIn) count_q <= '0;
        else        count_q <= count_d;
    end

    always_comb begin
        count_d = count_q;
        if (state_q == IDLE && start) count_d = '0;
        else if (hs)                  count_d = count_q + ADDR_WIDTH_CAM'(1);
    end

    assign match_count = count_q;
`else
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_match_reader.sv
// Directed bench for match_reader: a scan-level model predicts beats, done and busy
// every cycle, and directed literal checks pin the model on the key scenarios.
module tb_match_reader;
    import ap_pkg::*;

    localparam int DW = 8;
    localparam int DD = 16;
    localparam int AW = 8;
`ifdef MATCH_READER_COUNT_EN
    localparam bit COUNT_EN = 1'b1;
`else
    localparam bit COUNT_EN = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rstIn = 1'b0;
    logic          start = 1'b0;
    logic [DD-1:0] tag   = '0;
    logic [DW-1:0] q_row = '0;
    logic [AW-1:0] addr_row;
    logic [AW-1:0] match_count;
    logic [2:0]    input_mode;
    logic          busy;
    logic          done;
    state_e        state_dbg;

    match_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) out_if ();

    match_reader #(
        .DATA_WIDTH     (DW),
        .DATA_DEPTH     (DD),
        .ADDR_WIDTH_CAM (AW),
        .RowxRow        (MODE_ROWXROW)
    ) dut (
        .clk             (clk),
        .rstIn           (rstIn),
        .start           (start),
        .tag             (tag),
        .Q_out_row       (q_row),
        .addr_output_Row (addr_row),
        .input_mode      (input_mode),
        .busy            (busy),
        .done            (done),
        .match_count     (match_count),
        .state_dbg       (state_dbg),
        .out_if          (out_if)
    );

    // ---------------- clock / array model ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] mem [DD];
    always @(posedge clk) q_row <= mem[addr_row[3:0]];

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [AW-1:0] exp_a[$];
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] log_a[$];
    logic [DW-1:0] log_d[$];
    int            log_c[$];
    int            done_log[$];
    bit            active   = 1'b0;
    int            due      = 0;
    int            done_due = -1;
    int            exp_mc   = 0;

    // Scan-level model: a start seen while idle snapshots tag into an ordered beat list;
    // each beat is visible 3 cycles after the previous event, done one cycle after the last.
    always @(negedge clk) begin
        bit ev;
        bit eb;
        if (!rstIn) begin
            exp_a.delete();
            exp_q.delete();
            active   = 1'b0;
            due      = 0;
            done_due = -1;
            exp_mc   = 0;
        end
        ev = active && (exp_a.size() > 0) && (cyc >= due);
        eb = active && (cyc != done_due);
        chk("out_valid", out_if.out_valid, ev);
        if (ev) begin
            chk("out_addr", out_if.out_addr, exp_a[0]);
            chk("out_data", out_if.out_data, exp_q[0]);
        end
        chk("done", done, cyc == done_due);
        chk("busy", busy, eb);
        chk("input_mode", input_mode, eb ? 32'(MODE_ROWXROW) : 32'd0);
        chk("match_count", match_count, COUNT_EN ? exp_mc : 0);
        if (done) done_log.push_back(cyc);
        if (rstIn) begin
            if (ev && out_if.out_ready) begin
                log_a.push_back(exp_a[0]);
                log_d.push_back(exp_q[0]);
                log_c.push_back(cyc);
                void'(exp_a.pop_front());
                void'(exp_q.pop_front());
                exp_mc++;
                if (exp_a.size() == 0) done_due = cyc + 1;
                else                   due      = cyc + 3;
            end
            if (active && cyc == done_due) begin
                active = 1'b0;
            end else if (!active && start) begin
                for (int i = 0; i < DD; i++) begin
                    if (tag[i]) begin
                        exp_a.push_back(AW'(i));
                        exp_q.push_back(mem[i]);
                    end
                end
                active   = 1'b1;
                exp_mc   = 0;
                due      = cyc + 3;
                done_due = (exp_a.size() == 0) ? cyc + 1 : -1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [DD-1:0] t);
        tag   = t;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic clear_logs();
        log_a.delete();
        log_d.delete();
        log_c.delete();
        done_log.delete();
    endtask

    task automatic wait_done(input int budget, output int dcyc, output logic [AW-1:0] mc);
        int k;
        k    = 0;
        dcyc = -1;
        mc   = '0;
        while (k < budget) begin
            @(negedge clk);
            k++;
            if (done) begin
                dcyc = cyc;
                mc   = match_count;
                break;
            end
        end
        if (dcyc < 0) chk("done_timeout", 0, 1);
        step();
    endtask

    task automatic wait_valid(input int budget);
        int  k;
        bit  seen;
        k    = 0;
        seen = 1'b0;
        while (k < budget && !seen) begin
            @(negedge clk);
            k++;
            seen = out_if.out_valid;
        end
        if (!seen) chk("valid_timeout", 0, 1);
        step();
    endtask

    task automatic check_reset_outputs(input string tname);
        chk({tname, "_valid"}, out_if.out_valid, 0);
        chk({tname, "_busy"}, busy, 0);
        chk({tname, "_done"}, done, 0);
        chk({tname, "_count"}, match_count, 0);
        chk({tname, "_state"}, state_dbg, IDLE);
        chk({tname, "_mode"}, input_mode, 0);
        chk({tname, "_row_addr"}, addr_row, 0);
        chk({tname, "_out_addr"}, out_if.out_addr, 0);
        chk({tname, "_out_data"}, out_if.out_data, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int            s;
        int            dc;
        logic [AW-1:0] mc;
        for (int i = 0; i < DD; i++) mem[i] = 8'hA0 + 8'(i);
        out_if.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rstIn = 1'b1;
        step();
        step();

        // Empty tag: done one cycle after the start cycle; a start during DONE is dropped.
        clear_logs();
        s = cyc;
        do_start(16'h0000);
        tag   = 16'h0001;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (8) step();
        chk("t1_done_pulses", done_log.size(), 1);
        if (done_log.size() > 0) chk("t1_done_lat", done_log[0] - s, 1);
        chk("t1_beats", log_a.size(), 0);

        // Rows 0/5/15 with ready held high.
        out_if.out_ready = 1'b1;
        clear_logs();
        s = cyc;
        do_start(16'h8021);
        wait_done(60, dc, mc);
        chk("t2_beats", log_a.size(), 3);
        if (log_a.size() == 3) begin
            chk("t2_a0", log_a[0], 0);
            chk("t2_d0", log_d[0], 8'hA0);
            chk("t2_a1", log_a[1], 5);
            chk("t2_d1", log_d[1], 8'hA5);
            chk("t2_a2", log_a[2], 15);
            chk("t2_d2", log_d[2], 8'hAF);
            chk("t2_first_lat", log_c[0] - s, 3);
            chk("t2_spacing", log_c[2] - log_c[1], 3);
        end
        chk("t2_count", mc, COUNT_EN ? 3 : 0);
        chk("t2_done_pulses", done_log.size(), 1);

        // Backpressure: beat for row 2 held stable for 10 stalled cycles.
        out_if.out_ready = 1'b0;
        clear_logs();
        s = cyc;
        do_start(16'h0004);
        wait_valid(10);
        repeat (10) begin
            @(negedge clk);
            chk("t3_hold_valid", out_if.out_valid, 1);
            chk("t3_hold_addr", out_if.out_addr, 2);
            chk("t3_hold_data", out_if.out_data, 8'hA2);
        end
        step();
        out_if.out_ready = 1'b1;
        wait_done(20, dc, mc);
        chk("t3_beats", log_a.size(), 1);
        if (log_a.size() == 1) chk("t3_late_accept", (log_c[0] - s) >= 13, 1);

        // Restart and tag change while busy are both ignored.
        clear_logs();
        do_start(16'h0812);
        tag   = 16'hFFFF;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(60, dc, mc);
        chk("t4_beats", log_a.size(), 3);
        if (log_a.size() == 3) begin
            chk("t4_a0", log_a[0], 1);
            chk("t4_a1", log_a[1], 4);
            chk("t4_a2", log_a[2], 11);
            chk("t4_d2", log_d[2], 8'hAB);
        end
        tag = '0;
        step();

        // Reset during EMIT drops the beat; the next scan behaves as after power-up.
        clear_logs();
        do_start(16'h00F0);
        begin
            int k;
            k = 0;
            while (log_a.size() == 0 && k < 20) begin
                @(negedge clk);
                k++;
            end
            if (log_a.size() == 0) chk("t5_first_timeout", 0, 1);
        end
        step();
        out_if.out_ready = 1'b0;
        wait_valid(10);
        chk("t5_in_emit", state_dbg, EMIT);
        #2;
        rstIn = 1'b0;
        #1;
        check_reset_outputs("t5_rst");
        step();
        step();
        rstIn = 1'b1;
        step();
        out_if.out_ready = 1'b1;
        clear_logs();
        s = cyc;
        do_start(16'h0003);
        wait_done(40, dc, mc);
        chk("t5_beats", log_a.size(), 2);
        if (log_a.size() == 2) begin
            chk("t5_a0", log_a[0], 0);
            chk("t5_a1", log_a[1], 1);
            chk("t5_d1", log_d[1], 8'hA1);
            chk("t5_first_lat", log_c[0] - s, 3);
        end
        chk("t5_count", mc, COUNT_EN ? 2 : 0);

        // Full tag: 16 beats at 0..15, one every 3 cycles.
        clear_logs();
        s = cyc;
        do_start(16'hFFFF);
        wait_done(120, dc, mc);
        chk("t6_beats", log_a.size(), 16);
        if (log_a.size() == 16) begin
            chk("t6_first_lat", log_c[0] - s, 3);
            for (int i = 0; i < 16; i++) begin
                chk("t6_addr", log_a[i], i);
                chk("t6_data", log_d[i], 8'hA0 + i);
                if (i > 0) chk("t6_spacing", log_c[i] - log_c[i-1], 3);
            end
            chk("t6_done_lat", dc - log_c[15], 1);
        end
        chk("t6_count", mc, COUNT_EN ? 16 : 0);

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
